mux_bus_arbiter_4: RTL and testbench
====================================

Name: mux_bus_arbiter_4

Overview:
- Round-robin arbiter that shares one 8-bit 4:1 mux datapath (MUX_8_2 style, 2-bit select) between four requesters.
- Grants ownership to one requester at a time and drives the mux select.
- Moves accepted beats into a registered output with a valid strobe, gated by sink ready.
- Sits between peripheral/bus sources and the shared processor data bus; bursts are bounded unless the owner asserts lock.

Parameters:
- MAX_BURST, 4, maximum beats per ownership while lock is low (legal range 1..255).

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- req  input  4  request per source; bit i = source i
- lock  input  4  per-source burst-limit override
- din0  input  8  data from source 0
- din1  input  8  data from source 1
- din2  input  8  data from source 2
- din3  input  8  data from source 3
- ready  input  1  sink accepts a beat this cycle
- grant  output  4  one-hot owner, all-zero when idle
- sel  output  2  mux select = index of owner (drives MUX_8_2 S)
- dout  output  8  registered beat data
- dout_valid  output  1  one-cycle strobe per accepted beat
- dout_src  output  2  source index of the beat on dout

Behaviour:
- Reset (async assert, sync release): state=IDLE, grant=0, sel=0, dout=0, dout_valid=0, dout_src=0, last=3 (so source 0 has first priority), beat count=0.
- States: IDLE, BUSY.
- IDLE arbitration:
  - If req!=0, pick the first set bit scanning last+1, last+2, ... mod 4.
  - Next edge: grant=onehot(pick), sel=pick, last=pick, count=0, state=BUSY.
  - If req==0, stay in IDLE with grant=0 and sel holding its previous value.
- BUSY beat rule:
  - A beat is accepted when req[owner] & ready.
  - Next edge: dout=din[owner] (through the sel path), dout_src=owner, dout_valid=1, count+1.
  - Any other cycle: dout_valid=0 and dout/dout_src hold.
- BUSY release (evaluated each cycle, priority order):
  - (1) req[owner]==0: release with no beat.
  - (2) An accepted beat makes count+1==MAX_BURST while lock[owner]==0: that beat completes, then release.
  - On release, next edge: grant=0, state=IDLE.
  - Exactly one dead cycle separates consecutive owners.
- Requests from non-owners while BUSY are ignored; they are seen in IDLE.
- lock[owner]==1: no burst limit; count saturates at 255 and never wraps.
- lock dropping mid-burst with count>=MAX_BURST: release after the next accepted beat.
- ready low: no beat, count frozen, ownership kept; ready alone never causes release.
- Owner drops req in the same cycle ready is high: no beat (rule 1).
- Simultaneous requests on the same edge: round-robin only; no fixed priority beyond pointer order.
- Fairness: with all four requesting continuously, owners cycle 0,1,2,3,0…
- Latency: req to grant is 1 cycle from IDLE; beat to dout_valid is 1 cycle.
- Reset mid-burst: immediate return to reset values; the partial burst is lost.

Decomposition:
- Shared package/header holds:
  - state encodings ST_IDLE=1'b0, ST_BUSY=1'b1
  - SRC_W=2
  - NUM_SRC=4
  - COUNT_W=8
- One sub-module: rr_pick_4, combinational. Inputs req[3:0] and last[1:0]; outputs pick[1:0] and any.
- The data path instantiates the existing MUX_8_2 with S=sel; no new mux logic.

Test Plan:
- Reset mid-BUSY with req=4'b0001, ready=1 → all outputs 0 during reset; after release the first grant goes to source 0.
- req=4'b1111, lock=0, ready=1, MAX_BURST=4, din_i=8'h10+i → owners 0,1,2,3,0 with grant 0001,0010,0100,1000. Each owner gets 4 beats (dout 10,11,12,13), then one dead cycle with grant=0.
- req=4'b0100, lock=4'b0100, ready=1 for 10 cycles → source 2 keeps grant throughout, 10 dout_valid pulses with dout_src=2; req[2] low releases next cycle.
- Source 1 owner, ready toggling 1,0,0,1,1,1 → exactly 4 beats, count frozen on ready=0 cycles, release after the 4th beat.
- Source 3 owner drops req after 2 beats while req[0]=1 → grant=0 for one cycle, then grant=0001 (pointer wrap 3→0).
- req=4'b0000 for many cycles → state stays IDLE, grant=0, dout_valid=0, dout holds its last value.

Source files
------------

// File: rtl/mux_bus_arbiter_4_pkg.sv
// Shared definitions for the mux_bus_arbiter_4 slice.
// Contents: FSM state encoding, source/count widths, one-hot helper.
package mux_bus_arbiter_4_pkg;

    localparam int SRC_W   = 2;
    localparam int NUM_SRC = 4;
    localparam int COUNT_W = 8;

    // Beat counter saturates here when the owner holds lock.
    localparam logic [COUNT_W-1:0] COUNT_MAX = {COUNT_W{1'b1}};

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    function automatic logic [NUM_SRC-1:0] onehot(input logic [SRC_W-1:0] idx);
        logic [NUM_SRC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/mux_8_2.sv
// MUX_8_2: 8-bit wide 4:1 multiplexer with a 2-bit select.
// Ports: D0..D3 data inputs, S select, Y selected data.
module MUX_8_2 (
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    input  logic [1:0] S,
    output logic [7:0] Y
);

    always_comb begin
        unique case (S)
            2'd0:    Y = D0;
            2'd1:    Y = D1;
            2'd2:    Y = D2;
            default: Y = D3;
        endcase
    end

endmodule

// File: rtl/mux_bus_arbiter_4_rr_pick.sv
// rr_pick_4: combinational round-robin picker.
// Ports: req  - request vector, bit i = source i
//        last - index of the most recent owner
//        pick - first requesting source scanning last+1, last+2, ... mod 4
//        any  - at least one request is present
module rr_pick_4
    import mux_bus_arbiter_4_pkg::*;
(
    input  logic [NUM_SRC-1:0] req,
    input  logic [SRC_W-1:0]   last,
    output logic [SRC_W-1:0]   pick,
    output logic               any
);

    logic [SRC_W-1:0] idx;

    // NOTE: every variable written in a combinational block gets a default
    // first, so no path through the block leaves it unassigned (no latch).
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        // The offset wraps in SRC_W bits, so the final step (k = NUM_SRC)
        // revisits 'last' itself as the lowest-priority candidate.
        for (int k = 1; k <= NUM_SRC; k++) begin
            idx = last + SRC_W'(k);
            if (!any && req[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_bus_arbiter_4.sv
// mux_bus_arbiter_4: round-robin owner of a shared 8-bit 4:1 mux datapath.
// Ports: clk, reset_n (async active-low)
//        req/lock     - per-source request and burst-limit override
//        din0..din3   - source data, selected through MUX_8_2 by sel
//        ready        - sink accepts a beat this cycle
//        grant/sel    - one-hot owner and its index
//        dout/dout_valid/dout_src - registered beat, strobe and source index
module mux_bus_arbiter_4
    import mux_bus_arbiter_4_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req,
    input  logic [NUM_SRC-1:0] lock,
    input  logic [7:0]         din0,
    input  logic [7:0]         din1,
    input  logic [7:0]         din2,
    input  logic [7:0]         din3,
    input  logic               ready,
    output logic [NUM_SRC-1:0] grant,
    output logic [SRC_W-1:0]   sel,
    output logic [7:0]         dout,
    output logic               dout_valid,
    output logic [SRC_W-1:0]   dout_src
);

    state_t               state_q, state_d;
    logic [NUM_SRC-1:0]   grant_q, grant_d;
    logic [SRC_W-1:0]     sel_q, sel_d;
    logic [SRC_W-1:0]     last_q, last_d;
    logic [COUNT_W-1:0]   count_q, count_d;
    logic [7:0]           dout_q, dout_d;
    logic                 valid_q, valid_d;
    logic [SRC_W-1:0]     src_q, src_d;

    logic [SRC_W-1:0]     pick;
    logic                 any;
    logic [7:0]           mux_y;
    logic                 owner_req;
    logic                 beat;
    logic                 limit_hit;
    logic                 release_own;
    logic [COUNT_W-1:0]   count_inc;

    rr_pick_4 u_pick (
        .req  (req),
        .last (last_q),
        .pick (pick),
        .any  (any)
    );

    MUX_8_2 u_mux (
        .D0 (din0),
        .D1 (din1),
        .D2 (din2),
        .D3 (din3),
        .S  (sel_q),
        .Y  (mux_y)
    );

    // While BUSY, sel_q is the owner index.
    assign owner_req = req[sel_q];
    assign beat      = (state_q == ST_BUSY) && owner_req && ready;
    assign count_inc = (count_q == COUNT_MAX) ? count_q : count_q + 1'b1;
    // '>=' rather than '==' so a lock dropped after the limit was passed
    // still releases on the next accepted beat.
    assign limit_hit = !lock[sel_q] &&
                       ((32'(count_q) + 32'd1) >= 32'(MAX_BURST));
    assign release_own = (state_q == ST_BUSY) &&
                         (!owner_req || (beat && limit_hit));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (any)         state_d = ST_BUSY;
            ST_BUSY: if (release_own) state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        grant_d = grant_q;
        sel_d   = sel_q;
        last_d  = last_q;
        count_d = count_q;
        dout_d  = dout_q;
        src_d   = src_q;
        valid_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (any) begin
                    grant_d = onehot(pick);
                    sel_d   = pick;
                    last_d  = pick;
                    count_d = '0;
                end else begin
                    grant_d = '0;
                end
            end
            ST_BUSY: begin
                if (beat) begin
                    dout_d  = mux_y;
                    src_d   = sel_q;
                    valid_d = 1'b1;
                    count_d = count_inc;
                end
                if (release_own) grant_d = '0;
            end
            default: grant_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            grant_q <= '0;
            sel_q   <= '0;
            last_q  <= SRC_W'(NUM_SRC - 1);  // source 0 wins first
            count_q <= '0;
            dout_q  <= '0;
            valid_q <= 1'b0;
            src_q   <= '0;
        end else begin
            grant_q <= grant_d;
            sel_q   <= sel_d;
            last_q  <= last_d;
            count_q <= count_d;
            dout_q  <= dout_d;
            valid_q <= valid_d;
            src_q   <= src_d;
        end
    end

    assign grant      = grant_q;
    assign sel        = sel_q;
    assign dout       = dout_q;
    assign dout_valid = valid_q;
    assign dout_src   = src_q;

endmodule

// File: tb/tb_mux_bus_arbiter_4.sv
module tb_mux_bus_arbiter_4;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [3:0] req, lock;
    logic [7:0] din0, din1, din2, din3;
    logic       ready;
    logic [3:0] grant;
    logic [1:0] sel;
    logic [7:0] dout;
    logic       dout_valid;
    logic [1:0] dout_src;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [3:0] req;
        logic [3:0] lock;
        logic       ready;
        logic [3:0] exp_grant;
        logic [1:0] exp_sel;
        logic       exp_valid;
        logic [7:0] exp_dout;
        logic [1:0] exp_src;
    } vec_t;

    vec_t vecs[21];

    mux_bus_arbiter_4 #(.MAX_BURST(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .req        (req),
        .lock       (lock),
        .din0       (din0),
        .din1       (din1),
        .din2       (din2),
        .din3       (din3),
        .ready      (ready),
        .grant      (grant),
        .sel        (sel),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_src   (dout_src)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outs(input string tag, input logic [3:0] g, input logic [1:0] s,
                              input logic v, input logic [7:0] d, input logic [1:0] src);
        check({tag, ".grant"},      32'(grant),      32'(g));
        check({tag, ".sel"},        32'(sel),        32'(s));
        check({tag, ".dout_valid"}, 32'(dout_valid), 32'(v));
        check({tag, ".dout"},       32'(dout),       32'(d));
        check({tag, ".dout_src"},   32'(dout_src),   32'(src));
    endtask

    // Asserts reset between edges (so any zeroing is asynchronous),
    // checks the reset values, then releases away from the clock edge.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        check_outs({tag, ".in_reset"}, 4'b0000, 2'd0, 1'b0, 8'h00, 2'd0);
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
    endtask

    function automatic vec_t mk(input logic [3:0] g, input logic [1:0] s, input logic v,
                                input logic [7:0] d, input logic [1:0] src);
        vec_t r;
        r.req = 4'b1111; r.lock = 4'b0000; r.ready = 1'b1;
        r.exp_grant = g; r.exp_sel = s; r.exp_valid = v; r.exp_dout = d; r.exp_src = src;
        return r;
    endfunction

    initial begin
        int beats;
        logic rdy_seq[6];

        // Full rotation with all four requesting: per owner one grant cycle,
        // four beats (the fourth coincides with grant dropping), then the
        // dead cycle doubles as the next grant edge.
        vecs[0] = mk(4'b0001, 2'd0, 1'b0, 8'h00, 2'd0);
        for (int o = 0; o < 4; o++) begin
            if (o > 0) vecs[o*5] = mk(4'b0001 << o, 2'(o), 1'b0, 8'h10 + 8'(o-1), 2'(o-1));
            for (int b = 1; b <= 4; b++)
                vecs[o*5+b] = mk((b == 4) ? 4'b0000 : (4'b0001 << o), 2'(o), 1'b1,
                                 8'h10 + 8'(o), 2'(o));
        end
        vecs[20] = mk(4'b0001, 2'd0, 1'b0, 8'h13, 2'd3);

        din0 = 8'h10; din1 = 8'h11; din2 = 8'h12; din3 = 8'h13;
        req = '0; lock = '0; ready = 1'b0;
        reset_n = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;

        // Reset mid-burst.
        req = 4'b0001; ready = 1'b1;
        tick();
        check_outs("mid.grant", 4'b0001, 2'd0, 1'b0, 8'h00, 2'd0);
        tick();
        tick();
        check_outs("mid.beat2", 4'b0001, 2'd0, 1'b1, 8'h10, 2'd0);
        do_reset("mid");
        tick();
        check_outs("mid.regrant", 4'b0001, 2'd0, 1'b0, 8'h00, 2'd0);

        // Table-driven round robin.
        do_reset("rr");
        for (int i = 0; i < 21; i++) begin
            req = vecs[i].req; lock = vecs[i].lock; ready = vecs[i].ready;
            tick();
            check_outs($sformatf("rr[%0d]", i), vecs[i].exp_grant, vecs[i].exp_sel,
                       vecs[i].exp_valid, vecs[i].exp_dout, vecs[i].exp_src);
        end

        // Locked owner keeps grant past MAX_BURST.
        do_reset("lk");
        req = 4'b0100; lock = 4'b0100; ready = 1'b1;
        tick();
        check("lk.grant", 32'(grant), 32'(4'b0100));
        for (int i = 0; i < 10; i++) begin
            tick();
            check_outs($sformatf("lk[%0d]", i), 4'b0100, 2'd2, 1'b1, 8'h12, 2'd2);
        end
        req = 4'b0000;
        tick();
        check_outs("lk.drop", 4'b0000, 2'd2, 1'b0, 8'h12, 2'd2);

        // Ready toggling: count frozen while ready is low.
        do_reset("rdy");
        req = 4'b0010; lock = 4'b0000; ready = 1'b0;
        tick();
        check("rdy.grant", 32'(grant), 32'(4'b0010));
        rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        beats = 0;
        for (int i = 0; i < 6; i++) begin
            ready = rdy_seq[i];
            tick();
            if (dout_valid) beats++;
            check($sformatf("rdy[%0d].valid", i), 32'(dout_valid), 32'(rdy_seq[i]));
            check($sformatf("rdy[%0d].grant", i), 32'(grant),
                  (i == 5) ? 32'(4'b0000) : 32'(4'b0010));
        end
        check("rdy.beats", 32'(beats), 32'd4);

        // Owner 3 drops after two beats; pointer wraps to source 0.
        do_reset("wrap");
        req = 4'b1000; ready = 1'b1;
        tick();
        check_outs("wrap.grant3", 4'b1000, 2'd3, 1'b0, 8'h00, 2'd0);
        req = 4'b1001;
        tick();
        tick();
        check_outs("wrap.beat2", 4'b1000, 2'd3, 1'b1, 8'h13, 2'd3);
        req = 4'b0001;
        tick();
        check_outs("wrap.dead", 4'b0000, 2'd3, 1'b0, 8'h13, 2'd3);
        tick();
        check_outs("wrap.grant0", 4'b0001, 2'd0, 1'b0, 8'h13, 2'd3);

        // Owner drops req with ready high: no beat, then long idle.
        req = 4'b0000;
        tick();
        check_outs("idle.rel", 4'b0000, 2'd0, 1'b0, 8'h13, 2'd3);
        for (int i = 0; i < 8; i++) begin
            tick();
            check_outs($sformatf("idle[%0d]", i), 4'b0000, 2'd0, 1'b0, 8'h13, 2'd3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
